// File: rtl/short_circuit_tracker_if.sv
// Bundle of the control, issue and operand-select signals exchanged between
// the ID/EX issue logic and the short-circuit (forwarding/hazard) tracker.
interface short_circuit_tracker_if #(
  parameter int REG_ADDR_SIZE  = 5,
  parameter int FWD_STAGES     = 2,
  parameter int STALL_CNT_SIZE = 16
);
  localparam int SRC_W = $clog2(FWD_STAGES + 1);

  logic                      i_halt;
  logic                      i_flush;
  logic                      i_issue_valid;
  logic                      i_issue_wb;
  logic                      i_issue_is_load;
  logic [REG_ADDR_SIZE-1:0]  i_issue_dst;
  logic [REG_ADDR_SIZE-1:0]  i_id_rs;
  logic [REG_ADDR_SIZE-1:0]  i_id_rt;
  logic                      i_id_uses_rs;
  logic                      i_id_uses_rt;
  logic [REG_ADDR_SIZE-1:0]  i_ex_rs;
  logic [REG_ADDR_SIZE-1:0]  i_ex_rt;
  logic [SRC_W-1:0]          o_sc_data_a_src;
  logic [SRC_W-1:0]          o_sc_data_b_src;
  logic                      o_stall;
  logic [STALL_CNT_SIZE-1:0] o_stall_count;

  // Issue/pipeline side: drives requests, observes selects and stall
  modport master (
    output i_halt, i_flush, i_issue_valid, i_issue_wb, i_issue_is_load, i_issue_dst,
           i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_ex_rs, i_ex_rt,
    input  o_sc_data_a_src, o_sc_data_b_src, o_stall, o_stall_count
  );

  // Tracker side
  modport slave (
    input  i_halt, i_flush, i_issue_valid, i_issue_wb, i_issue_is_load, i_issue_dst,
           i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt, i_ex_rs, i_ex_rt,
    output o_sc_data_a_src, o_sc_data_b_src, o_stall, o_stall_count
  );
endinterface

// File: rtl/short_circuit_tracker.sv
// Forwarding/hazard tracker for the pipelined datapath.
// Keeps a shift pipeline of in-flight destinations (entry 0 = EX, 1 = EX/MEM,
// 2 = MEM/WB, ...), produces EX operand forwarding selects, detects load-use
// hazards for the instruction in ID and counts the stall cycles it inserts.
module short_circuit_tracker #(
  parameter int REG_ADDR_SIZE  = 5,
  parameter int FWD_STAGES     = 2,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int STALL_CNT_SIZE = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  short_circuit_tracker_if.slave sc
);
  localparam int SRC_W = $clog2(FWD_STAGES + 1);
  localparam int NENT  = FWD_STAGES + 1;

  typedef struct packed {
    logic                     valid;
    logic                     wb;
    logic                     is_load;
    logic [REG_ADDR_SIZE-1:0] dst;
  } entry_t;

  localparam entry_t ENTRY_NONE = entry_t'('0);

  entry_t                    entry_q [NENT];
  entry_t                    entry_d [NENT];
  logic [STALL_CNT_SIZE-1:0] cnt_q;
  logic [STALL_CNT_SIZE-1:0] cnt_d;
  logic                      stall_s;
  logic [SRC_W-1:0]          a_src_s;
  logic [SRC_W-1:0]          b_src_s;

  // Entry at stage k can supply register r (r0 never forwards; loads only
  // once their data has arrived at LOAD_FWD_STAGE).
  function automatic logic fwd_cand(entry_t e, int k, logic [REG_ADDR_SIZE-1:0] r);
    return e.valid && e.wb && (e.dst == r) && (r != {REG_ADDR_SIZE{1'b0}}) &&
           (!e.is_load || (k >= LOAD_FWD_STAGE));
  endfunction

  // Load in stage e whose result the ID instruction needs before it can forward.
  function automatic logic load_hazard(entry_t e);
    return e.valid && e.wb && e.is_load && (e.dst != {REG_ADDR_SIZE{1'b0}}) &&
           (((e.dst == sc.i_id_rs) && sc.i_id_uses_rs) ||
            ((e.dst == sc.i_id_rt) && sc.i_id_uses_rt));
  endfunction

  // Forwarding selects: scan oldest to youngest so the youngest match shadows older ones.
  always_comb begin
    a_src_s = {SRC_W{1'b0}};
    b_src_s = {SRC_W{1'b0}};
    for (int k = FWD_STAGES; k >= 1; k--) begin
      a_src_s = fwd_cand(entry_q[k], k, sc.i_ex_rs) ? SRC_W'(k) : a_src_s;
      b_src_s = fwd_cand(entry_q[k], k, sc.i_ex_rt) ? SRC_W'(k) : b_src_s;
    end
  end

  // Load-use stall: any too-young load feeding ID; flush and halt suppress it.
  always_comb begin
    stall_s = 1'b0;
    for (int j = 0; j < LOAD_FWD_STAGE - 1; j++) begin
      stall_s = stall_s | load_hazard(entry_q[j]);
    end
    if (sc.i_flush || sc.i_halt) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_s;
    end
  end

  // Next state: shift the tracker, admit the issuing instruction or a bubble, count stalls.
  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    if (!sc.i_halt) begin
      for (int k = 1; k < NENT; k++) begin
        entry_d[k] = entry_q[k-1];
      end
      if (sc.i_issue_valid && !stall_s && !sc.i_flush) begin
        entry_d[0] = '{valid: 1'b1, wb: sc.i_issue_wb, is_load: sc.i_issue_is_load,
                       dst: sc.i_issue_dst};
      end else begin
        entry_d[0] = ENTRY_NONE;
      end
      if (stall_s && (cnt_q != {STALL_CNT_SIZE{1'b1}})) begin
        cnt_d = cnt_q + {{(STALL_CNT_SIZE-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NENT; k++) begin
        entry_q[k] <= ENTRY_NONE;
      end
      cnt_q <= {STALL_CNT_SIZE{1'b0}};
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sc.o_sc_data_a_src = a_src_s;
  assign sc.o_sc_data_b_src = b_src_s;
  assign sc.o_stall         = stall_s;
  assign sc.o_stall_count   = cnt_q;
endmodule

// File: tb/tb_short_circuit_tracker.sv
// Directed bench for short_circuit_tracker: stimulus pushes hand-computed
// expectations into a scoreboard queue; a negedge monitor pops and compares.
module tb_short_circuit_tracker;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  short_circuit_tracker_if ifa ();
  short_circuit_tracker_if #(.STALL_CNT_SIZE(2)) ifb ();

  short_circuit_tracker dut_a (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .sc       (ifa.slave)
  );

  short_circuit_tracker #(.STALL_CNT_SIZE(2)) dut_b (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .sc       (ifb.slave)
  );

  typedef struct {
    int unit;
    int tag;
    int a;
    int b;
    int st;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tagn  = 0;

  task automatic chk(input int unit, input int a, input int b, input int st, input int cnt);
    exp_t e;
    e.unit = unit; e.tag = tagn; e.a = a; e.b = b; e.st = st; e.cnt = cnt;
    tagn++;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int h, input int f, input int iv, input int wb, input int ld,
                     input int dst, input int idrs, input int urs, input int idrt,
                     input int urt, input int exrs, input int exrt);
    ifa.i_halt          = 1'(h);
    ifa.i_flush         = 1'(f);
    ifa.i_issue_valid   = 1'(iv);
    ifa.i_issue_wb      = 1'(wb);
    ifa.i_issue_is_load = 1'(ld);
    ifa.i_issue_dst     = 5'(dst);
    ifa.i_id_rs         = 5'(idrs);
    ifa.i_id_uses_rs    = 1'(urs);
    ifa.i_id_rt         = 5'(idrt);
    ifa.i_id_uses_rt    = 1'(urt);
    ifa.i_ex_rs         = 5'(exrs);
    ifa.i_ex_rt         = 5'(exrt);
  endtask

  task automatic drvb(input int iv, input int ld, input int dst, input int idrs, input int urs);
    ifb.i_halt          = 1'b0;
    ifb.i_flush         = 1'b0;
    ifb.i_issue_valid   = 1'(iv);
    ifb.i_issue_wb      = 1'(iv);
    ifb.i_issue_is_load = 1'(ld);
    ifb.i_issue_dst     = 5'(dst);
    ifb.i_id_rs         = 5'(idrs);
    ifb.i_id_uses_rs    = 1'(urs);
    ifb.i_id_rt         = 5'd0;
    ifb.i_id_uses_rt    = 1'b0;
    ifb.i_ex_rs         = 5'd0;
    ifb.i_ex_rt         = 5'd0;
  endtask

  // Monitor: compare every pending expectation against the live DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    int aa, bb, ss, cc;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.unit == 0) begin
        aa = int'(ifa.o_sc_data_a_src); bb = int'(ifa.o_sc_data_b_src);
        ss = int'(ifa.o_stall);         cc = int'(ifa.o_stall_count);
      end else begin
        aa = int'(ifb.o_sc_data_a_src); bb = int'(ifb.o_sc_data_b_src);
        ss = int'(ifb.o_stall);         cc = int'(ifb.o_stall_count);
      end
      n_vec++;
      if (aa != e.a || bb != e.b || ss != e.st || cc != e.cnt) begin
        n_bad++;
        $display("FAIL vec%0d unit%0d: got a_src=%0d b_src=%0d stall=%0d count=%0d, expected a_src=%0d b_src=%0d stall=%0d count=%0d",
                 e.tag, e.unit, aa, bb, ss, cc, e.a, e.b, e.st, e.cnt);
      end
    end
  end

  initial begin
    // Reset with random inputs on both units
    rst_n = 1'b0;
    drv(int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)),
        int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(31)),
        int'($urandom_range(31)), int'($urandom_range(1)), int'($urandom_range(31)),
        int'($urandom_range(1)), int'($urandom_range(31)), int'($urandom_range(31)));
    drvb(int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(31)),
         int'($urandom_range(31)), int'($urandom_range(1)));
    chk(0, 0, 0, 0, 0);
    chk(1, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    drvb(0, 0, 0, 0, 0);

    // ALU chain: add $3 forwards from stage 1, then 2, then not at all
    drv(0,0,1,1,0,3, 0,0,0,0, 0,0); chk(0,0,0,0,0); tick();
    drv(0,0,1,0,0,0, 0,0,0,0, 3,0); chk(0,0,0,0,0); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 3,0); chk(0,1,0,0,0); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 3,0); chk(0,2,0,0,0); tick();
    // Shadowing: add $5 then sub $5; younger one wins
    drv(0,0,1,1,0,5, 0,0,0,0, 3,0); chk(0,0,0,0,0); tick();
    drv(0,0,1,1,0,5, 0,0,0,0, 0,5); chk(0,0,0,0,0); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 0,5); chk(0,0,1,0,0); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 5,5); chk(0,1,1,0,0); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 5,5); chk(0,2,2,0,0); tick();
    // Load-use: lw $4 then dependent add $6
    drv(0,0,1,1,1,4, 0,0,0,0, 0,0); chk(0,0,0,0,0); tick();
    drv(0,0,1,1,0,6, 4,1,0,0, 4,0); chk(0,0,0,1,0); tick();
    drv(0,0,1,1,0,6, 4,1,0,0, 4,0); chk(0,0,0,0,1); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 4,0); chk(0,2,0,0,1); tick();
    // Register 0 never forwards nor stalls
    drv(0,0,1,1,0,0, 0,0,0,0, 0,0); chk(0,0,0,0,1); tick();
    drv(0,0,1,1,1,0, 0,0,0,0, 0,0); chk(0,0,0,0,1); tick();
    drv(0,0,0,0,0,0, 0,1,0,0, 0,0); chk(0,0,0,0,1); tick();
    // Flush beats a load-use stall and inserts a bubble
    drv(0,0,1,1,1,7, 0,0,0,0, 0,0); chk(0,0,0,0,1); tick();
    drv(0,1,1,1,0,8, 0,0,7,1, 0,0); chk(0,0,0,0,1); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 7,8); chk(0,0,0,0,1); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 7,8); chk(0,2,0,0,1); tick();
    // Halt: state frozen for 3 cycles, stall suppressed, then resumes
    drv(0,0,1,1,0,9, 0,0,0,0, 0,0); chk(0,0,0,0,1); tick();
    drv(0,0,1,1,1,12, 0,0,0,0, 9,0); chk(0,0,0,0,1); tick();
    for (int i = 0; i < 3; i++) begin
      drv(1,0,1,1,0,11, 12,1,0,0, 9,12); chk(0,1,0,0,1); tick();
    end
    drv(0,0,1,1,0,11, 12,1,0,0, 9,12); chk(0,1,0,1,1); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 9,12); chk(0,2,0,0,2); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 9,12); chk(0,0,2,0,2); tick();
    // Reset mid-stall clears entries, stall and counter immediately
    drv(0,0,1,1,1,13, 0,0,0,0, 0,0); chk(0,0,0,0,2); tick();
    drv(0,0,1,1,0,14, 13,1,0,0, 0,0); chk(0,0,0,1,2); tick();
    rst_n = 1'b0;
    drv(0,0,1,1,0,14, 13,1,0,0, 13,0); chk(0,0,0,0,0); tick();
    rst_n = 1'b1;
    drv(0,0,1,1,0,14, 13,1,0,0, 13,0); chk(0,0,0,0,0); tick();
    drv(0,0,0,0,0,0, 0,0,0,0, 0,0);

    // Saturation on the 2-bit counter unit: 5 stalls -> 3
    for (int i = 0; i < 5; i++) begin
      drvb(1, 1, 4, 0, 0); chk(1, 0, 0, 0, (i > 3) ? 3 : i); tick();
      drvb(0, 0, 0, 4, 1); chk(1, 0, 0, 1, (i > 3) ? 3 : i); tick();
    end
    drvb(0, 0, 0, 0, 0); chk(1, 0, 0, 0, 3); tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
